// File: rtl/fp_lsu_if.sv
// Bundles the FP register-file request channel, the DCCM port and the
// writeback/status outputs of the FP load/store unit.
interface fp_lsu_if;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_store_i;
  logic [31:0] req_addr_i;
  logic [31:0] req_wdata_i;
  logic [4:0]  req_frd_i;

  logic        dccm_req_o;
  logic        dccm_we_o;
  logic [31:0] dccm_addr_o;
  logic [31:0] dccm_wdata_o;
  logic        dccm_gnt_i;
  logic        dccm_rvalid_i;
  logic [31:0] dccm_rdata_i;

  logic        fp_load_en_o;
  logic [4:0]  frd_load_o;
  logic [31:0] load_data_o;
  logic        misaligned_o;
  logic        timeout_o;
  logic        busy_o;

  // The LSU itself is the slave: it receives requests and drives the DCCM port.
  modport slave (
    input  req_valid_i, req_store_i, req_addr_i, req_wdata_i, req_frd_i,
    input  dccm_gnt_i, dccm_rvalid_i, dccm_rdata_i,
    output req_ready_o, dccm_req_o, dccm_we_o, dccm_addr_o, dccm_wdata_o,
    output fp_load_en_o, frd_load_o, load_data_o, misaligned_o, timeout_o, busy_o
  );

  modport master (
    output req_valid_i, req_store_i, req_addr_i, req_wdata_i, req_frd_i,
    output dccm_gnt_i, dccm_rvalid_i, dccm_rdata_i,
    input  req_ready_o, dccm_req_o, dccm_we_o, dccm_addr_o, dccm_wdata_o,
    input  fp_load_en_o, frd_load_o, load_data_o, misaligned_o, timeout_o, busy_o
  );
endinterface

// File: rtl/fp_lsu.sv
// FP load/store unit: one FLW/FSW in flight, single-word DCCM access with
// alignment check, read-data timeout and a one-cycle FP register writeback.
module fp_lsu #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic    clk_i,
  input  logic    rst_i,
  fp_lsu_if.slave bus
);

  typedef enum logic [2:0] {IDLE, REQ, WAIT_R, WB, ERR} state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      state;
  logic [7:0]  cnt;
  logic        store_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [4:0]  frd_q;
  logic [31:0] rdata_q;
  logic        load_en_q;
  logic        mis_q;
  logic        tmo_q;

  // NOTE: all state uses non-blocking assignments so every branch below sees
  // the pre-edge values; mixing blocking here would create order-dependent logic.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= IDLE;
      cnt       <= '0;
      // NOTE: the captured request/response registers are plain flops, not a
      // memory, so they are cleared here and outputs driven from them read 0.
      store_q   <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      frd_q     <= '0;
      rdata_q   <= '0;
      load_en_q <= 1'b0;
      mis_q     <= 1'b0;
      tmo_q     <= 1'b0;
    end else begin
      load_en_q <= 1'b0;
      mis_q     <= 1'b0;
      tmo_q     <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.req_valid_i) begin
            store_q <= bus.req_store_i;
            addr_q  <= {bus.req_addr_i[31:2], 2'b00};
            wdata_q <= bus.req_wdata_i;
            frd_q   <= bus.req_frd_i;
            if (bus.req_addr_i[1:0] != 2'b00) begin
              state <= ERR;
              mis_q <= 1'b1;
            end else begin
              state <= REQ;
            end
          end
        end
        REQ: begin
          if (bus.dccm_gnt_i) begin
            if (store_q) begin
              state <= IDLE;
            end else if (bus.dccm_rvalid_i) begin
              rdata_q   <= bus.dccm_rdata_i;
              load_en_q <= 1'b1;
              state     <= WB;
            end else begin
              cnt   <= '0;
              state <= WAIT_R;
            end
          end
        end
        WAIT_R: begin
          if (bus.dccm_rvalid_i) begin
            rdata_q   <= bus.dccm_rdata_i;
            load_en_q <= 1'b1;
            state     <= WB;
          end else if (cnt == CNT_LAST) begin
            tmo_q <= 1'b1;
            state <= IDLE;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        WB:      state <= IDLE;
        ERR:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready_o  = (state == IDLE);
  assign bus.busy_o       = (state != IDLE);
  assign bus.dccm_req_o   = (state == REQ);
  assign bus.dccm_we_o    = (state == REQ) && store_q;
  assign bus.dccm_addr_o  = addr_q;
  assign bus.dccm_wdata_o = wdata_q;
  assign bus.fp_load_en_o = load_en_q;
  assign bus.frd_load_o   = frd_q;
  assign bus.load_data_o  = rdata_q;
  assign bus.misaligned_o = mis_q;
  assign bus.timeout_o    = tmo_q;

endmodule

// File: tb/tb_fp_lsu.sv
// Directed bench for fp_lsu: stimulus pushes expected DCCM accesses and
// writeback/error pulses into a scoreboard that a negedge monitor drains.
module tb_fp_lsu;

  typedef enum logic [1:0] {EV_DCCM, EV_WB, EV_MIS, EV_TMO} ev_kind_t;

  typedef struct {
    ev_kind_t    kind;
    logic [31:0] addr;
    logic [31:0] data;
    logic        we;
    logic [4:0]  frd;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  ev_t  sb[$];

  fp_lsu_if bus ();

  fp_lsu #(.TIMEOUT_CYCLES(4)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_ev(input ev_kind_t k, input logic [31:0] a, input logic [31:0] d,
                           input logic we, input logic [4:0] frd);
    ev_t e;
    e.kind = k;
    e.addr = a;
    e.data = d;
    e.we   = we;
    e.frd  = frd;
    sb.push_back(e);
  endtask

  task automatic observe(input ev_kind_t k, input logic [31:0] a, input logic [31:0] d,
                         input logic we, input logic [4:0] frd);
    ev_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_event: got kind %0d with nothing expected at %0t", k, $time);
    end else begin
      e = sb.pop_front();
      check("event_kind", 32'(k), 32'(e.kind));
      if (e.kind == k && k == EV_DCCM) begin
        check("dccm_addr", a, e.addr);
        check("dccm_wdata", d, e.data);
        check("dccm_we", 32'(we), 32'(e.we));
      end else if (e.kind == k && k == EV_WB) begin
        check("frd_load", 32'(frd), 32'(e.frd));
        check("load_data", d, e.data);
      end
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.dccm_req_o && bus.dccm_gnt_i)
        observe(EV_DCCM, bus.dccm_addr_o, bus.dccm_wdata_o, bus.dccm_we_o, 5'd0);
      if (bus.fp_load_en_o)
        observe(EV_WB, 32'd0, bus.load_data_o, 1'b0, bus.frd_load_o);
      if (bus.misaligned_o)
        observe(EV_MIS, 32'd0, 32'd0, 1'b0, 5'd0);
      if (bus.timeout_o)
        observe(EV_TMO, 32'd0, 32'd0, 1'b0, 5'd0);
    end
  end

  task automatic check_reset_outputs(input string tag);
    @(negedge clk);
    check({tag, "_ready"},    32'(bus.req_ready_o), 32'd1);
    check({tag, "_busy"},     32'(bus.busy_o), 32'd0);
    check({tag, "_dccm_req"}, 32'(bus.dccm_req_o), 32'd0);
    check({tag, "_we"},       32'(bus.dccm_we_o), 32'd0);
    check({tag, "_addr"},     bus.dccm_addr_o, 32'd0);
    check({tag, "_wdata"},    bus.dccm_wdata_o, 32'd0);
    check({tag, "_load_en"},  32'(bus.fp_load_en_o), 32'd0);
    check({tag, "_frd"},      32'(bus.frd_load_o), 32'd0);
    check({tag, "_ldata"},    bus.load_data_o, 32'd0);
    check({tag, "_mis"},      32'(bus.misaligned_o), 32'd0);
    check({tag, "_tmo"},      32'(bus.timeout_o), 32'd0);
  endtask

  task automatic issue(input logic store, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [4:0] frd);
    bus.req_valid_i = 1'b1;
    bus.req_store_i = store;
    bus.req_addr_i  = addr;
    bus.req_wdata_i = wdata;
    bus.req_frd_i   = frd;
    tick();
    bus.req_valid_i = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while (!bus.req_ready_o && n < budget) begin
      tick();
      n++;
    end
    if (!bus.req_ready_o) begin
      checks++;
      errors++;
      $display("FAIL %s_idle_timeout: got busy after %0d cycles expected idle", tag, budget);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish before 100000");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.req_valid_i   = 1'b0;
    bus.req_store_i   = 1'b0;
    bus.req_addr_i    = '0;
    bus.req_wdata_i   = '0;
    bus.req_frd_i     = '0;
    bus.dccm_gnt_i    = 1'b0;
    bus.dccm_rvalid_i = 1'b0;
    bus.dccm_rdata_i  = '0;

    tick();
    tick();
    check_reset_outputs("reset");
    rst = 1'b0;
    tick();

    // Store, grant on the third REQ cycle.
    expect_ev(EV_DCCM, 32'h0000_1008, 32'h3F80_0000, 1'b1, 5'd0);
    issue(1'b1, 32'h0000_1008, 32'h3F80_0000, 5'd0);
    for (int i = 0; i < 3; i++) begin
      bus.dccm_gnt_i = (i == 2);
      @(negedge clk);
      check("st_req_held", 32'(bus.dccm_req_o), 32'd1);
      check("st_req_addr", bus.dccm_addr_o, 32'h0000_1008);
      check("st_req_we", 32'(bus.dccm_we_o), 32'd1);
      check("st_ready_low", 32'(bus.req_ready_o), 32'd0);
      tick();
    end
    bus.dccm_gnt_i = 1'b0;
    @(negedge clk);
    check("st_idle_after", 32'(bus.req_ready_o), 32'd1);
    check("st_req_dropped", 32'(bus.dccm_req_o), 32'd0);
    tick();

    // Load, immediate grant, read data two cycles later.
    expect_ev(EV_DCCM, 32'h0000_0040, 32'h3F80_0000, 1'b0, 5'd0);
    expect_ev(EV_WB, 32'd0, 32'h4049_0FDB, 1'b0, 5'd7);
    bus.dccm_gnt_i = 1'b1;
    issue(1'b0, 32'h0000_0040, 32'h3F80_0000, 5'd7);
    tick();
    bus.dccm_gnt_i = 1'b0;
    @(negedge clk);
    check("ld_wait_no_req", 32'(bus.dccm_req_o), 32'd0);
    tick();
    bus.dccm_rvalid_i = 1'b1;
    bus.dccm_rdata_i  = 32'h4049_0FDB;
    tick();
    bus.dccm_rvalid_i = 1'b0;
    @(negedge clk);
    check("ld_wb_strobe", 32'(bus.fp_load_en_o), 32'd1);
    tick();
    @(negedge clk);
    check("ld_wb_single", 32'(bus.fp_load_en_o), 32'd0);
    check("ld_idle_after", 32'(bus.req_ready_o), 32'd1);

    // Load with grant and rvalid together; rvalid seen in IDLE must be ignored.
    expect_ev(EV_DCCM, 32'h0000_0100, 32'h3F80_0000, 1'b0, 5'd0);
    expect_ev(EV_WB, 32'd0, 32'hC000_0000, 1'b0, 5'd31);
    bus.dccm_gnt_i    = 1'b1;
    bus.dccm_rvalid_i = 1'b1;
    bus.dccm_rdata_i  = 32'hDEAD_BEEF;
    issue(1'b0, 32'h0000_0100, 32'h3F80_0000, 5'd31);
    bus.dccm_rdata_i  = 32'hC000_0000;
    tick();
    bus.dccm_gnt_i    = 1'b0;
    bus.dccm_rvalid_i = 1'b0;
    @(negedge clk);
    check("fast_ld_latency2", 32'(bus.fp_load_en_o), 32'd1);
    tick();

    // Misaligned load: error pulse, no DCCM access even with grant asserted.
    expect_ev(EV_MIS, 32'd0, 32'd0, 1'b0, 5'd0);
    bus.dccm_gnt_i = 1'b1;
    issue(1'b0, 32'h0000_0042, 32'h0, 5'd3);
    @(negedge clk);
    check("mis_busy", 32'(bus.busy_o), 32'd1);
    check("mis_no_req", 32'(bus.dccm_req_o), 32'd0);
    tick();
    @(negedge clk);
    check("mis_ready_2cyc", 32'(bus.req_ready_o), 32'd1);
    check("mis_pulse_gone", 32'(bus.misaligned_o), 32'd0);
    check("mis_no_req_after", 32'(bus.dccm_req_o), 32'd0);
    bus.dccm_gnt_i = 1'b0;
    tick();

    // Load timeout after 4 WAIT_R cycles; late rvalid ignored.
    expect_ev(EV_DCCM, 32'h0000_0080, 32'h0, 1'b0, 5'd0);
    expect_ev(EV_TMO, 32'd0, 32'd0, 1'b0, 5'd0);
    bus.dccm_gnt_i = 1'b1;
    issue(1'b0, 32'h0000_0080, 32'h0, 5'd9);
    tick();
    bus.dccm_gnt_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("tmo_waiting", 32'(bus.busy_o), 32'd1);
      check("tmo_not_yet", 32'(bus.timeout_o), 32'd0);
      tick();
    end
    @(negedge clk);
    check("tmo_pulse", 32'(bus.timeout_o), 32'd1);
    check("tmo_idle", 32'(bus.req_ready_o), 32'd1);
    bus.dccm_rvalid_i = 1'b1;
    bus.dccm_rdata_i  = 32'h1234_5678;
    tick();
    bus.dccm_rvalid_i = 1'b0;
    tick();
    @(negedge clk);
    check("tmo_no_wb", 32'(bus.fp_load_en_o), 32'd0);

    // Reset in WAIT_R, then a stray rvalid.
    expect_ev(EV_DCCM, 32'h0000_0200, 32'h0, 1'b0, 5'd0);
    bus.dccm_gnt_i = 1'b1;
    issue(1'b0, 32'h0000_0200, 32'h0, 5'd1);
    tick();
    bus.dccm_gnt_i = 1'b0;
    @(negedge clk);
    check("rst_in_wait", 32'(bus.busy_o), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset_outputs("midrst");
    bus.dccm_rvalid_i = 1'b1;
    bus.dccm_rdata_i  = 32'hFFFF_FFFF;
    tick();
    bus.dccm_rvalid_i = 1'b0;
    tick();
    @(negedge clk);
    check("midrst_no_wb", 32'(bus.fp_load_en_o), 32'd0);

    wait_idle("final", 20);
    tick();
    check("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
